// File: rtl/arith_stream_pkg.sv
// Shared types and helpers for the arithmetic streaming blocks.
// Holds the argmax FSM state encoding and the frame index width rule.
package arith_stream_pkg;

    typedef enum logic {
        ACC = 1'b0,
        OUT = 1'b1
    } argmax_state_e;

    // Index width for a frame; a single-sample frame still needs one bit.
    function automatic int idx_width(input int frame_len);
        return (frame_len > 1) ? $clog2(frame_len) : 1;
    endfunction

endpackage

// File: rtl/CmpGE.sv
// Unsigned A >= B comparator, evaluated as the carry out of A - B.
// Latency: combinational. Backpressure: none, pure function of A and B.
// speed selects the carry network: 0 ripple, 1 Brent-Kung, 2 Sklansky.
module CmpGE #(
    parameter int width = 8,
    parameter int speed = 1
) (
    input  logic [width-1:0] A,
    input  logic [width-1:0] B,
    output logic             GE
);

    localparam int N = width + 1;

    function automatic logic ge_calc(input logic [width-1:0] a, input logic [width-1:0] b);
        logic [N-1:0] g;
        logic [N-1:0] p;
        int           j;
        int           top;
        // Position 0 models the +1 carry-in of the two's complement subtract.
        g = {a & ~b, 1'b1};
        p = {~(a ^ b), 1'b0};
        if (speed == 0) begin
            for (int i = 1; i < N; i++) begin
                g[i] = g[i] | (p[i] & g[i-1]);
            end
        end else if (speed == 2) begin
            for (int l = 0; (1 << l) < N; l++) begin
                for (int i = 0; i < N; i++) begin
                    if (((i >> l) & 1) != 0) begin
                        j    = ((i >> l) << l) - 1;
                        g[i] = g[i] | (p[i] & g[j]);
                        p[i] = p[i] & p[j];
                    end
                end
            end
        end else begin
            for (int s = 1; s < N; s = s * 2) begin
                for (int i = 2 * s - 1; i < N; i += 2 * s) begin
                    g[i] = g[i] | (p[i] & g[i-s]);
                    p[i] = p[i] & p[i-s];
                end
            end
            top = 1;
            while (top * 2 < N) top = top * 2;
            for (int s = top; s >= 1; s = s / 2) begin
                for (int i = 3 * s - 1; i < N; i += 2 * s) begin
                    g[i] = g[i] | (p[i] & g[i-s]);
                    p[i] = p[i] & p[i-s];
                end
            end
        end
        return g[N-1];
    endfunction

    assign GE = ge_calc(A, B);

endmodule

// File: rtl/stream_argmax.sv
// Per-frame argmax: maximum unsigned sample and index of its first occurrence.
// Latency: result valid the cycle after the last sample of a frame is accepted.
// Backpressure: in_ready_o stays low while a result waits on out_ready_i.
module stream_argmax
    import arith_stream_pkg::*;
#(
    parameter int  WIDTH     = 8,
    parameter int  SPEED     = 1,
    parameter int  FRAME_LEN = 16,
    localparam int IDX_W     = idx_width(FRAME_LEN)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_max_o,
    output logic [IDX_W-1:0] out_idx_o
);

    argmax_state_e    state;
    logic [IDX_W-1:0] cnt;
    logic [IDX_W-1:0] idx_q;
    logic [WIDTH-1:0] max_q;
    logic             ge;
    logic             in_fire;
    logic             last;

    CmpGE #(
        .width (WIDTH),
        .speed (SPEED)
    ) u_cmp (
        .A  (max_q),
        .B  (in_data_i),
        .GE (ge)
    );

    assign in_ready_o  = (state == ACC) && !flush_i && !rst_i;
    assign in_fire     = in_valid_i && in_ready_o;
    assign last        = (cnt == IDX_W'(FRAME_LEN - 1));
    assign out_valid_o = (state == OUT);
    assign out_max_o   = out_valid_o ? max_q : '0;
    assign out_idx_o   = out_valid_o ? idx_q : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ACC;
            cnt   <= '0;
            max_q <= '0;
            idx_q <= '0;
        end else if (flush_i) begin
            state <= ACC;
            cnt   <= '0;
        end else begin
            case (state)
                ACC: begin
                    if (in_fire) begin
                        // Strictly greater replaces, so ties keep the earlier index.
                        if (cnt == '0 || !ge) begin
                            max_q <= in_data_i;
                            idx_q <= cnt;
                        end
                        if (last) begin
                            cnt   <= '0;
                            state <= OUT;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                OUT: begin
                    if (out_ready_i) state <= ACC;
                end
                default: state <= ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_argmax.sv
// Bench for stream_argmax: one instance per comparator speed, shared stimulus,
// results scored against a behavioural argmax model through a queue.
module tb_stream_argmax;

    localparam int WIDTH     = 8;
    localparam int FRAME_LEN = 4;
    localparam int IDX_W     = 2;
    localparam int NDUT      = 3;

    typedef struct packed {
        logic [WIDTH-1:0] mx;
        logic [IDX_W-1:0] ix;
    } res_t;

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             flush     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] in_data   = '0;
    logic             in_ready  [NDUT];
    logic             out_valid [NDUT];
    logic [WIDTH-1:0] out_max   [NDUT];
    logic [IDX_W-1:0] out_idx   [NDUT];

    int               tests = 0;
    int               fails = 0;
    res_t             sb[$];
    int               mcnt  = 0;
    logic [WIDTH-1:0] mmax  = '0;
    logic [IDX_W-1:0] midx  = '0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < NDUT; k++) begin : g_dut
        stream_argmax #(
            .WIDTH     (WIDTH),
            .SPEED     (k),
            .FRAME_LEN (FRAME_LEN)
        ) u_dut (
            .clk_i       (clk),
            .rst_i       (rst),
            .flush_i     (flush),
            .in_valid_i  (in_valid),
            .in_ready_o  (in_ready[k]),
            .in_data_i   (in_data),
            .out_valid_o (out_valid[k]),
            .out_ready_i (out_ready),
            .out_max_o   (out_max[k]),
            .out_idx_o   (out_idx[k])
        );
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_clear();
        mcnt = 0;
    endtask

    task automatic model_accept(input logic [WIDTH-1:0] v);
        if (mcnt == 0 || v > mmax) begin
            mmax = v;
            midx = IDX_W'(mcnt);
        end
        mcnt++;
        if (mcnt == FRAME_LEN) begin
            sb.push_back('{mx: mmax, ix: midx});
            mcnt = 0;
        end
    endtask

    // Presents one sample and returns at the negedge after it was taken.
    task automatic send(input logic [WIDTH-1:0] v);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = v;
        #1;
        while (!in_ready[0] && guard < 64) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!in_ready[0]) begin
            tests++;
            fails++;
            $display("FAIL send_timeout data=%0d in_ready=%0b required 1", v, in_ready[0]);
        end else begin
            @(negedge clk);
            model_accept(v);
        end
        in_valid = 1'b0;
        if (guard >= 64) @(negedge clk);
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d);
        send(a);
        send(b);
        send(c);
        send(d);
    endtask

    task automatic check_out(input string name);
        int   guard = 0;
        res_t e;
        #1;
        while (!out_valid[0] && guard < 40) begin
            @(negedge clk);
            #1;
            guard++;
        end
        tests++;
        if (!out_valid[0]) begin
            fails++;
            $display("FAIL %s_timeout out_valid=%0b required 1", name, out_valid[0]);
        end else if (sb.size() == 0) begin
            fails++;
            $display("FAIL %s_unexpected result max=%0d idx=%0d with empty scoreboard", name, out_max[0], out_idx[0]);
        end else begin
            e = sb.pop_front();
            for (int k = 0; k < NDUT; k++) begin
                tests++;
                if (out_max[k] !== e.mx || out_idx[k] !== e.ix) begin
                    fails++;
                    $display("FAIL %s speed=%0d got max=%0d idx=%0d expected max=%0d idx=%0d",
                             name, k, out_max[k], out_idx[k], e.mx, e.ix);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            tests++;
            if (in_ready[k] !== 1'b0 || out_valid[k] !== 1'b0 || out_max[k] !== '0 || out_idx[k] !== '0) begin
                fails++;
                $display("FAIL reset_state speed=%0d got rdy=%0b vld=%0b max=%0d idx=%0d expected all 0",
                         k, in_ready[k], out_valid[k], out_max[k], out_idx[k]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            tests++;
            if (in_ready[k] !== 1'b1) begin
                fails++;
                $display("FAIL reset_release speed=%0d in_ready=%0b expected 1", k, in_ready[k]);
            end
        end
        @(negedge clk);
        model_clear();
    endtask

    task automatic test_basic();
        send(3);
        send(9);
        send(2);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            tests++;
            if (out_valid[k] !== 1'b0) begin
                fails++;
                $display("FAIL latency_early speed=%0d out_valid=%0b expected 0", k, out_valid[k]);
            end
        end
        send(7);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            tests++;
            if (out_valid[k] !== 1'b1) begin
                fails++;
                $display("FAIL latency_one speed=%0d out_valid=%0b expected 1", k, out_valid[k]);
            end
        end
        check_out("basic_3927");
        #1;
        for (int k = 0; k < NDUT; k++) begin
            tests++;
            if (out_valid[k] !== 1'b0) begin
                fails++;
                $display("FAIL result_consumed speed=%0d out_valid=%0b expected 0", k, out_valid[k]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_ties();
        send_frame(5, 5, 1, 5);
        check_out("ties_5515");
        send_frame(0, 0, 0, 0);
        check_out("all_zero");
    endtask

    task automatic test_boundaries();
        send_frame(0, 255, 254, 255);
        check_out("bound_255");
        send_frame(255, 200, 100, 0);
        check_out("descending");
        send_frame(7, 7, 7, 8);
        check_out("last_sample_max");
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send_frame(10, 30, 20, 30);
        check_out("bp_first");
        in_valid = 1'b1;
        in_data  = 1;
        repeat (5) begin
            #1;
            for (int k = 0; k < NDUT; k++) begin
                tests++;
                if (out_valid[k] !== 1'b1 || out_max[k] !== 30 || out_idx[k] !== 1 || in_ready[k] !== 1'b0) begin
                    fails++;
                    $display("FAIL bp_hold speed=%0d got vld=%0b max=%0d idx=%0d rdy=%0b expected vld=1 max=30 idx=1 rdy=0",
                             k, out_valid[k], out_max[k], out_idx[k], in_ready[k]);
                end
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        send_frame(1, 2, 3, 4);
        check_out("bp_next_1234");
    endtask

    task automatic test_flush();
        send(10);
        send(20);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 99;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            tests++;
            if (in_ready[k] !== 1'b0) begin
                fails++;
                $display("FAIL flush_ready speed=%0d in_ready=%0b expected 0", k, in_ready[k]);
            end
        end
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        model_clear();
        send_frame(6, 1, 8, 2);
        check_out("flush_6182");

        out_ready = 1'b0;
        send_frame(1, 2, 3, 4);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            tests++;
            if (out_valid[k] !== 1'b0) begin
                fails++;
                $display("FAIL flush_out speed=%0d out_valid=%0b expected 0", k, out_valid[k]);
            end
        end
        if (sb.size() > 0) void'(sb.pop_back());
        out_ready = 1'b1;
        @(negedge clk);
        send_frame(2, 9, 9, 3);
        check_out("after_flush_out");
    endtask

    task automatic test_reset_mid();
        send(200);
        send(201);
        rst = 1'b1;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            tests++;
            if (in_ready[k] !== 1'b0) begin
                fails++;
                $display("FAIL rst_ready speed=%0d in_ready=%0b expected 0", k, in_ready[k]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        send_frame(4, 7, 7, 1);
        check_out("rst_mid_next");

        out_ready = 1'b0;
        send_frame(1, 5, 2, 0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            tests++;
            if (out_valid[k] !== 1'b0 || out_max[k] !== '0 || out_idx[k] !== '0 || in_ready[k] !== 1'b0) begin
                fails++;
                $display("FAIL rst_out speed=%0d got vld=%0b max=%0d idx=%0d rdy=%0b expected all 0",
                         k, out_valid[k], out_max[k], out_idx[k], in_ready[k]);
            end
        end
        if (sb.size() > 0) void'(sb.pop_back());
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        model_clear();
        send_frame(9, 3, 9, 12);
        check_out("after_rst_out");
    endtask

    task automatic test_random();
        int nfr = 1000;
        fork
            begin
                for (int f = 0; f < nfr; f++) begin
                    for (int s = 0; s < FRAME_LEN; s++) begin
                        repeat ($urandom_range(0, 2)) @(negedge clk);
                        if ($urandom_range(0, 1) == 1) send(WIDTH'($urandom_range(0, 255)));
                        else send(WIDTH'($urandom_range(0, 3)));
                    end
                end
            end
            begin
                int   got  = 0;
                int   cyc  = 0;
                logic hold = 1'b0;
                res_t e    = '0;
                while (got < nfr && cyc < 40000) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 3) != 0);
                    #1;
                    cyc++;
                    if (out_valid[0]) begin
                        if (!hold) begin
                            if (sb.size() == 0) begin
                                tests++;
                                fails++;
                                $display("FAIL rand_unexpected max=%0d idx=%0d with empty scoreboard", out_max[0], out_idx[0]);
                            end else begin
                                e = sb.pop_front();
                            end
                        end
                        for (int k = 0; k < NDUT; k++) begin
                            tests++;
                            if (out_valid[k] !== 1'b1 || out_max[k] !== e.mx || out_idx[k] !== e.ix) begin
                                fails++;
                                $display("FAIL rand_result frame=%0d speed=%0d got vld=%0b max=%0d idx=%0d expected vld=1 max=%0d idx=%0d",
                                         got, k, out_valid[k], out_max[k], out_idx[k], e.mx, e.ix);
                            end
                        end
                        hold = !out_ready;
                        if (out_ready) got++;
                    end else if (hold) begin
                        tests++;
                        fails++;
                        $display("FAIL rand_valid_dropped frame=%0d out_valid=0 expected 1", got);
                        hold = 1'b0;
                    end
                end
                tests++;
                if (got != nfr) begin
                    fails++;
                    $display("FAIL rand_count got=%0d frames expected %0d", got, nfr);
                end
            end
        join
        out_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL rand_leftover scoreboard size=%0d expected 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ties();
        test_boundaries();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
